// File: rtl/t1_common_pkg.sv
// Shared types for the t1 sim-control blocks.
//   mon_state_e : idle-monitor FSM states
//   error_e     : accounting error codes reported by the idle monitor
package t1_common_pkg;

  typedef enum logic [1:0] {
    MON_BUSY,
    MON_DRAIN,
    MON_IDLE,
    MON_ERROR
  } mon_state_e;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_UNDERFLOW_R,
    ERR_UNDERFLOW_W,
    ERR_UNDERFLOW_B,
    ERR_OVERFLOW
  } error_e;

endpackage

// File: rtl/t1_idle_monitor_if.sv
// Bus-event / status bundle between the sim-control shell and the idle monitor.
//   master : shell side, drives init_flag, core_busy and the *_fire events
//   slave  : monitor side, returns idle, outstanding counts and the error status
interface t1_idle_monitor_if
  import t1_common_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 64
) ();

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic             init_flag;
  logic             core_busy;
  logic             ar_fire;
  logic             r_last_fire;
  logic             aw_fire;
  logic             w_last_fire;
  logic             b_fire;
  logic             idle;
  logic [CNT_W-1:0] rd_outstanding;
  logic [CNT_W-1:0] wdata_pending;
  logic [CNT_W-1:0] wr_outstanding;
  logic             error;
  error_e           error_code;

  modport master (
    output init_flag, core_busy, ar_fire, r_last_fire, aw_fire, w_last_fire, b_fire,
    input  idle, rd_outstanding, wdata_pending, wr_outstanding, error, error_code
  );

  modport slave (
    input  init_flag, core_busy, ar_fire, r_last_fire, aw_fire, w_last_fire, b_fire,
    output idle, rd_outstanding, wdata_pending, wr_outstanding, error, error_code
  );

endinterface

// File: rtl/t1_outstanding_counter.sv
// Saturating up/down counter of in-flight transactions.
//   clock, reset_n : clock, async active-low reset
//   en             : events are only counted while high
//   inc, dec       : one transaction issued / retired this cycle
//   cnt            : registered count
//   underflow      : dec at zero without inc (count holds)
//   overflow       : inc at MAX without dec (count holds)
module t1_outstanding_counter #(
  parameter int unsigned MAX   = 64,
  parameter int unsigned CNT_W = $clog2(MAX + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    overflow  = 1'b0;
    if (en) begin
      unique case ({inc, dec})
        2'b10: begin
          if (cnt_q == MaxCnt) overflow = 1'b1;
          else                 cnt_d    = cnt_q + One;
        end
        2'b01: begin
          if (cnt_q == '0) underflow = 1'b1;
          else             cnt_d     = cnt_q - One;
        end
        // Simultaneous inc and dec cancel; no event leaves the count alone.
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/t1_idle_monitor.sv
// Idle monitor for the sim-control shell.
// Tracks outstanding AXI reads (AR vs R-last), write data (AW vs W-last) and write
// responses (AW vs B); asserts idle once everything is drained, the core is not busy
// and the bus has been quiet for QUIET_CYCLES consecutive cycles. Accounting errors
// are latched (first one wins) and park the FSM in MON_ERROR until reset.
//   clock, reset_n : clock, async active-low reset
//   mon_if         : slave side of t1_idle_monitor_if (events in, status out)
module t1_idle_monitor
  import t1_common_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 64,
  parameter int unsigned QUIET_CYCLES    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  t1_idle_monitor_if.slave  mon_if
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned QW    = $clog2(QUIET_CYCLES + 1);
  localparam logic [QW-1:0] QuietLast = QW'(QUIET_CYCLES - 1);
  localparam logic [QW-1:0] QuietOne  = QW'(1);

  logic             cnt_en;
  logic [CNT_W-1:0] rd_cnt, wd_cnt, wr_cnt;
  logic             rd_unf, rd_ovf, wd_unf, wd_ovf, wr_unf, wr_ovf;
  logic             any_fire, quiet;
  error_e           err_now;

  mon_state_e       state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  error_e           error_code_q, error_code_d;

  assign cnt_en = ~mon_if.init_flag;

  t1_outstanding_counter #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_rd_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (cnt_en),
    .inc       (mon_if.ar_fire),
    .dec       (mon_if.r_last_fire),
    .cnt       (rd_cnt),
    .underflow (rd_unf),
    .overflow  (rd_ovf)
  );

  t1_outstanding_counter #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_wd_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (cnt_en),
    .inc       (mon_if.aw_fire),
    .dec       (mon_if.w_last_fire),
    .cnt       (wd_cnt),
    .underflow (wd_unf),
    .overflow  (wd_ovf)
  );

  t1_outstanding_counter #(.MAX(MAX_OUTSTANDING), .CNT_W(CNT_W)) u_wr_cnt (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (cnt_en),
    .inc       (mon_if.aw_fire),
    .dec       (mon_if.b_fire),
    .cnt       (wr_cnt),
    .underflow (wr_unf),
    .overflow  (wr_ovf)
  );

  assign any_fire = mon_if.ar_fire | mon_if.r_last_fire | mon_if.aw_fire |
                    mon_if.w_last_fire | mon_if.b_fire;

  // Quiet requires no events this cycle, so the post-update counts equal the
  // current registered counts and can be used directly.
  assign quiet = (rd_cnt == '0) && (wd_cnt == '0) && (wr_cnt == '0) &&
                 !mon_if.core_busy && !any_fire && !mon_if.init_flag;

  // Priority encode this cycle's error; the counters already gate on init_flag.
  always_comb begin
    err_now = ERR_NONE;
    if      (rd_unf)                    err_now = ERR_UNDERFLOW_R;
    else if (wd_unf)                    err_now = ERR_UNDERFLOW_W;
    else if (wr_unf)                    err_now = ERR_UNDERFLOW_B;
    else if (rd_ovf || wd_ovf || wr_ovf) err_now = ERR_OVERFLOW;
  end

  always_comb begin
    state_d      = state_q;
    qcnt_d       = qcnt_q;
    error_code_d = error_code_q;
    if (state_q != MON_ERROR && err_now != ERR_NONE) begin
      state_d      = MON_ERROR;
      error_code_d = err_now;
      qcnt_d       = '0;
    end else begin
      unique case (state_q)
        MON_BUSY: begin
          if (quiet) begin
            if (QUIET_CYCLES == 1) begin
              state_d = MON_IDLE;
              qcnt_d  = '0;
            end else begin
              state_d = MON_DRAIN;
              qcnt_d  = QuietOne;
            end
          end
        end
        MON_DRAIN: begin
          if (!quiet) begin
            state_d = MON_BUSY;
            qcnt_d  = '0;
          end else if (qcnt_q == QuietLast) begin
            state_d = MON_IDLE;
            qcnt_d  = '0;
          end else begin
            qcnt_d = qcnt_q + QuietOne;
          end
        end
        MON_IDLE: begin
          if (!quiet) state_d = MON_BUSY;
        end
        MON_ERROR: begin
          state_d = MON_ERROR;
        end
        default: begin
          state_d = MON_BUSY;
          qcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MON_BUSY;
      qcnt_q       <= '0;
      error_code_q <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      qcnt_q       <= qcnt_d;
      error_code_q <= error_code_d;
    end
  end

  assign mon_if.idle           = (state_q == MON_IDLE);
  assign mon_if.error          = (state_q == MON_ERROR);
  assign mon_if.error_code     = error_code_q;
  assign mon_if.rd_outstanding = rd_cnt;
  assign mon_if.wdata_pending  = wd_cnt;
  assign mon_if.wr_outstanding = wr_cnt;

endmodule
